// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient controller, the filter and the benches.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } fir_state_e;

  // Reset value of tap 0 in the active bank; every other tap resets to zero.
  localparam int unsigned IDENTITY_TAP0 = 1;

  function automatic int unsigned cnt_width(input int unsigned taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient register arrays; the shadow is loaded one tap
// at a time and copied wholesale into the active bank on a single strobe.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned NUM_OF_TAPS = 3,
  parameter int unsigned COEF_WIDTH  = 8,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en_i,
  input  logic [IDX_W-1:0]                  wr_idx_i,
  input  logic [COEF_WIDTH-1:0]             wr_data_i,
  input  logic                              clear_i,
  input  logic                              copy_i,
  output logic [NUM_OF_TAPS*COEF_WIDTH-1:0] coef_flat_o
);

  logic [COEF_WIDTH-1:0] shadow_q [NUM_OF_TAPS];
  logic [COEF_WIDTH-1:0] active_q [NUM_OF_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_OF_TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= (i == 0) ? COEF_WIDTH'(IDENTITY_TAP0) : '0;
      end
    end else begin
      // A discarded set wins over the write of the beat that caused the discard.
      for (int unsigned i = 0; i < NUM_OF_TAPS; i++) begin
        if (clear_i) begin
          shadow_q[i] <= '0;
        end else if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          shadow_q[i] <= wr_data_i;
        end
      end
      if (copy_i) begin
        for (int unsigned i = 0; i < NUM_OF_TAPS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  always_comb begin
    coef_flat_o = '0;
    for (int unsigned k = 0; k < NUM_OF_TAPS; k++) begin
      coef_flat_o[k*COEF_WIDTH +: COEF_WIDTH] = active_q[k];
    end
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient-load controller in front of fir_filter: serial load into a shadow
// bank, length check, atomic swap at a sample boundary, 1-cycle sample forward.
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned NUM_OF_TAPS = 3,
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned COEF_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [COEF_WIDTH-1:0]             cfg_data,
  input  logic                              cfg_last,
  output logic                              cfg_err,
  output logic                              commit,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INPUT_WIDTH-1:0]            in_data,
  output logic [INPUT_WIDTH-1:0]            fir_input_data,
  output logic                              fir_input_data_flag,
  output logic [NUM_OF_TAPS*COEF_WIDTH-1:0] coef_flat
);

  localparam int unsigned      CNT_W    = cnt_width(NUM_OF_TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OF_TAPS - 1);

  fir_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   commit_q, commit_d;
  logic [INPUT_WIDTH-1:0] data_q;
  logic                   flag_q;

  logic             beat_acc;
  logic             beat_at_end;
  logic             beat_done;
  logic             beat_bad;
  logic [CNT_W-1:0] wr_idx;
  logic             copy;

  assign cfg_ready = (state_q != ST_COMMIT);
  assign in_ready  = (state_q != ST_COMMIT);

  // IDLE always writes tap 0, so the counter value there is irrelevant.
  assign beat_acc    = cfg_valid & cfg_ready;
  assign wr_idx      = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign beat_at_end = (wr_idx == LAST_IDX);
  assign beat_done   = beat_acc &  cfg_last &  beat_at_end;
  assign beat_bad    = beat_acc & (cfg_last ^  beat_at_end);
  assign copy        = (state_q == ST_COMMIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    commit_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (beat_done) begin
          state_d = ST_COMMIT;
        end else if (beat_bad) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          cfg_err_d = 1'b1;
        end else if (beat_acc) begin
          state_d = ST_LOAD;
          cnt_d   = wr_idx + 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        commit_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
      commit_q  <= 1'b0;
      data_q    <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      commit_q  <= commit_d;
      data_q    <= in_data;
      flag_q    <= in_valid & in_ready;
    end
  end

  assign cfg_err             = cfg_err_q;
  assign commit              = commit_q;
  assign fir_input_data      = data_q;
  assign fir_input_data_flag = flag_q;

  fir_coef_bank #(
    .NUM_OF_TAPS (NUM_OF_TAPS),
    .COEF_WIDTH  (COEF_WIDTH),
    .IDX_W       (CNT_W)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (beat_acc),
    .wr_idx_i    (wr_idx),
    .wr_data_i   (cfg_data),
    .clear_i     (beat_bad),
    .copy_i      (copy),
    .coef_flat_o (coef_flat)
  );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Bench for fir_coef_ctrl: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a beat-list reference model.
module tb_fir_coef_ctrl;

  localparam int N  = 3;
  localparam int IW = 8;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_data = '0;
  logic            cfg_last = 1'b0;
  logic            cfg_err;
  logic            commit;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IW-1:0]   in_data = '0;
  logic [IW-1:0]   fir_input_data;
  logic            fir_input_data_flag;
  logic [N*CW-1:0] coef_flat;

  fir_coef_ctrl #(
    .NUM_OF_TAPS (N),
    .INPUT_WIDTH (IW),
    .COEF_WIDTH  (CW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .cfg_data            (cfg_data),
    .cfg_last            (cfg_last),
    .cfg_err             (cfg_err),
    .commit              (commit),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .fir_input_data      (fir_input_data),
    .fir_input_data_flag (fir_input_data_flag),
    .coef_flat           (coef_flat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a set is a list of beats; it is good only when cfg_last
  // arrives exactly on beat N. A good set causes one stall cycle, then swaps.
  logic [CW-1:0] m_beats[$];
  logic [CW-1:0] m_active[N] = '{8'd1, 8'd0, 8'd0};
  logic [CW-1:0] m_pend[N]   = '{8'd0, 8'd0, 8'd0};
  bit            m_stall  = 0;
  bit            m_flag   = 0;
  logic [IW-1:0] m_data   = '0;
  bit            m_err    = 0;
  bit            m_commit = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_beats.delete();
      m_active = '{8'd1, 8'd0, 8'd0};
      m_stall  = 0;
      m_flag   = 0;
      m_data   = '0;
      m_err    = 0;
      m_commit = 0;
    end else begin
      m_flag   = in_valid && !m_stall;
      m_data   = in_data;
      m_err    = 0;
      m_commit = 0;
      if (m_stall) begin
        m_active = m_pend;
        m_commit = 1;
        m_stall  = 0;
      end else if (cfg_valid) begin
        m_beats.push_back(cfg_data);
        if (cfg_last && m_beats.size() == N) begin
          for (int k = 0; k < N; k++) m_pend[k] = m_beats[k];
          m_beats.delete();
          m_stall = 1;
        end else if (cfg_last || m_beats.size() == N) begin
          m_err = 1;
          m_beats.delete();
        end
      end
    end
  end

  logic [IW-1:0] fwd[$];
  int            n_commit = 0;
  int            n_err    = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_stall));
      chk("in_ready",  32'(in_ready),  32'(!m_stall));
      chk("flag",      32'(fir_input_data_flag), 32'(m_flag));
      if (m_flag) chk("data", 32'(fir_input_data), 32'(m_data));
      chk("cfg_err",   32'(cfg_err), 32'(m_err));
      chk("commit",    32'(commit),  32'(m_commit));
      chk("coef_flat", 32'(coef_flat), 32'({m_active[2], m_active[1], m_active[0]}));
      if (fir_input_data_flag) fwd.push_back(fir_input_data);
      if (commit) n_commit++;
      if (cfg_err) n_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [CW-1:0] d, input logic l);
    bit done;
    bit r;
    done = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      r = cfg_ready;
      tick();
      if (r) done = 1;
    end
    if (!done) chk("beat_accept_timeout", 32'd0, 32'd1);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  logic [IW-1:0] samp[6]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
  logic [CW-1:0] beats[3] = '{8'h10, 8'h20, 8'h30};

  initial begin
    int bi, si, stalls, base_err, base_commit;
    bit ir, cr, prev_stall, commit_checked;

    // 1: reset values
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_coef", 32'(coef_flat), 32'h000001);
    chk("t1_err", 32'(cfg_err), 32'd0);
    chk("t1_commit", 32'(commit), 32'd0);
    chk("t1_flag", 32'(fir_input_data_flag), 32'd0);
    chk("t1_data", 32'(fir_input_data), 32'd0);
    chk("t1_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // 2: single sample forward
    tick();
    in_valid = 1'b1;
    in_data  = 8'hDE;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    chk("t2_flag_hi", 32'(fir_input_data_flag), 32'd1);
    chk("t2_data", 32'(fir_input_data), 32'hDE);
    tick();
    @(negedge clk);
    chk("t2_flag_lo", 32'(fir_input_data_flag), 32'd0);

    // 3 + 5: load 10/20/30 while streaming six samples every cycle
    tick();
    fwd.delete();
    bi = 0; si = 0; stalls = 0; prev_stall = 0; commit_checked = 0;
    for (int c = 0; c < 20 && (si < 6 || bi < 3); c++) begin
      cfg_valid = (bi < 3);
      cfg_data  = beats[(bi < 3) ? bi : 2];
      cfg_last  = (bi == 2);
      in_valid  = (si < 6);
      in_data   = samp[(si < 6) ? si : 5];
      @(negedge clk);
      cr = cfg_ready;
      ir = in_ready;
      if (prev_stall) begin
        chk("t3_commit", 32'(commit), 32'd1);
        chk("t3_coef", 32'(coef_flat), 32'h302010);
        commit_checked = 1;
      end
      prev_stall = !ir;
      if (!ir) stalls++;
      tick();
      if (cfg_valid && cr) bi++;
      if (in_valid && ir) si++;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("t3_commit_seen", 32'(commit_checked), 32'd1);
    chk("t5_stalls", 32'(stalls), 32'd1);
    chk("t5_count", 32'(fwd.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < fwd.size()) chk("t5_order", 32'(fwd[i]), 32'(samp[i]));
    chk("t3_coef_hold", 32'(coef_flat), 32'h302010);

    // 4: short set -> error, bank unchanged
    base_err = n_err;
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    tick();
    chk("t4_err_pulses", 32'(n_err - base_err), 32'd1);
    chk("t4_coef", 32'(coef_flat), 32'h302010);
    chk("t4_idle_ready", 32'(cfg_ready), 32'd1);

    // 6: reset mid-load, then a fresh load from tap 0
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_coef", 32'(coef_flat), 32'h000001);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    base_commit = n_commit;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b1);
    tick(); tick();
    chk("t6_commit", 32'(n_commit - base_commit), 32'd1);
    chk("t6_coef", 32'(coef_flat), 32'h030201);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cfg_valid = ($urandom_range(0, 1) == 1);
      cfg_data  = CW'($urandom);
      cfg_last  = ($urandom_range(0, 3) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = IW'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
      end
      tick();
    end
    cfg_valid = 1'b0; cfg_last = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
